mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Multi-cycle HI/LO multiply/divide unit for the MIPS core; executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the single-cycle ALU on the same srca/srcb operand buses.
- The controller issues a start pulse and stalls on busy.
- Results land in architectural HI/LO registers, which MFHI/MFLO read through ports hi/lo.

Parameters:
WIDTH, 32, operand and HI/LO register width
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin an operation; sampled only in IDLE
md_ctrl  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
srca  input  WIDTH  multiplicand / dividend
srcb  input  WIDTH  multiplier / divisor
hilo_we  input  2  bit1: write HI, bit0: write LO (MTHI/MTLO)
wdata  input  WIDTH  write data for hilo_we
busy  output  1  operation in progress; the controller stalls while high
done  output  1  one-cycle pulse when HI/LO have been updated by an operation
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (sync, active-high) wins over all inputs:
  - state=IDLE; hi=0, lo=0, busy=0, done=0, counter=0.
  - An in-flight operation is aborted with no HI/LO update.
- State machine:
  - IDLE --(start)--> CALC: operands and md_ctrl latched. Signed ops store magnitudes plus result signs: product sign = a^b; quotient sign = a^b; remainder sign = sign of a.
  - CALC: one radix-2 step per clock for exactly WIDTH clocks.
    - Multiply: shift-add on the 2*WIDTH accumulator.
    - Divide: restoring shift-subtract.
  - CALC --(counter==WIDTH-1)--> FIX.
  - FIX --> IDLE: sign correction is applied (two's complement negate where required), hi/lo are written, and done=1 for exactly that following cycle.
- busy = (state != IDLE), registered.
- Latency:
  - start sampled at edge E0; busy=1 after E0.
  - hi/lo valid and done=1 after edge E(WIDTH+1), i.e. E33 for WIDTH=32.
  - busy=0 in the same cycle done=1.
- Multiply result: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned per md_ctrl.
- Divide result: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Division by zero (DIV and DIVU): lo = all ones, hi = srca (original dividend). Takes the normal latency; no exception.
- DIV of most-negative by -1: lo = 0x80000000, hi = 0. No trap.
- start while busy: ignored; no queueing.
- start in the cycle done=1: accepted, since state is already IDLE.
- hilo_we:
  - In IDLE it writes wdata into HI and/or LO at the next edge.
  - While busy it is dropped.
  - hilo_we together with start in IDLE: the write applies, and the operation's final result later overwrites both registers.
- hi/lo are held unchanged during CALC; intermediate values are never visible on the ports.
- done is never asserted for MTHI/MTLO writes.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 clocks done=1 for one cycle; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT -3 x 5, then MULT 10 x 15 -> first: hi=0xFFFFFFFF, lo=0xFFFFFFF1; second: hi=0, lo=150 (0x96).
- DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
- Corner cases:
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x1234.
  - DIV -5/0 -> lo=0xFFFFFFFF, hi=0xFFFFFFFB.
- Handshake and writes:
  - Start MULTU 2x3, then pulse start with DIVU 9/3 and assert hilo_we=11 (wdata=0xDEAD) at cycle 10 -> both ignored; result hi=0, lo=6.
  - Next, in IDLE, hilo_we=10 with wdata=0xBEEF -> hi=0xBEEF, lo=6, done stays 0.
- Reset mid-operation:
  - Start MULTU 7x7, assert reset at cycle 15 -> next cycle hi=lo=0, busy=0, done=0; done never pulses.
  - A new start then completes normally after 33 clocks.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// WIDTH iterations plus one sign-fix cycle, with direct HI/LO writes while idle.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       md_ctrl,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [1:0]       hilo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               is_div_q, is_div_d;
    logic               div_zero_q, div_zero_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q;
    logic               done_q, done_d;

    logic               is_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        is_signed = ~md_ctrl[0];
        a_neg     = is_signed & srca[WIDTH-1];
        b_neg     = is_signed & srcb[WIDTH-1];
        a_mag     = a_neg ? -srca : srca;
        b_mag     = b_neg ? -srcb : srcb;

        // Multiply: p holds {partial product high, remaining multiplier bits}.
        mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? m_q : '0)};
        // Divide: p holds {partial remainder, dividend bits shifting into quotient bits}.
        div_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, m_q};

        prod_fix = neg_q ? -p_q : p_q;
        quo_fix  = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        rem_fix  = rem_neg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        m_d        = m_q;
        p_d        = p_q;
        is_div_d   = is_div_q;
        div_zero_d = div_zero_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (hilo_we[1]) hi_d = wdata;
                if (hilo_we[0]) lo_d = wdata;
                if (start) begin
                    state_d    = StCalc;
                    cnt_d      = '0;
                    is_div_d   = md_ctrl[1];
                    div_zero_d = (srcb == '0);
                    neg_d      = a_neg ^ b_neg;
                    rem_neg_d  = a_neg;
                    if (md_ctrl[1]) begin
                        m_d = b_mag;
                        p_d = {{WIDTH{1'b0}}, a_mag};
                    end else begin
                        m_d = a_mag;
                        p_d = {{WIDTH{1'b0}}, b_mag};
                    end
                end
            end
            StCalc: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (is_div_q) begin
                    if (!div_diff[WIDTH]) begin
                        p_d = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
                    end else begin
                        p_d = {div_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    p_d = {mul_sum, p_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFix;
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (is_div_q) begin
                    // Zero divisor leaves the dividend magnitude as remainder, so rem_fix == srca.
                    lo_d = div_zero_q ? '1 : quo_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            m_q        <= '0;
            p_q        <= '0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            m_q        <= m_d;
            p_q        <= p_d;
            is_div_q   <= is_div_d;
            div_zero_q <= div_zero_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= (state_d != StIdle);
            done_q     <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table of MULT/DIV results plus hand-written
// handshake, MTHI/MTLO and mid-operation reset sequences.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  md_ctrl;
    logic [31:0] srca, srcb;
    logic [1:0]  hilo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [1:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[13];

    mul_div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_ctrl (md_ctrl),
        .srca    (srca),
        .srcb    (srcb),
        .hilo_we (hilo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive a start at a negedge; returns at the negedge just after the sampling edge.
    task automatic start_op(input logic [1:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        md_ctrl = ctrl;
        srca    = a;
        srcb    = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // n0 = edges already elapsed since the start edge; done must appear 33 edges after it.
    task automatic wait_done(input string name, input int n0, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input bit chk_pulse);
        int n = n0;
        int busy_cnt = n0;
        while (!done && n < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        check({name, " done"}, {31'b0, done}, 32'd1);
        check({name, " latency"}, n, 32'd33);
        check({name, " busy_cycles"}, busy_cnt, 32'd33);
        check({name, " busy_at_done"}, {31'b0, busy}, 32'd0);
        check({name, " hi"}, hi, exp_hi);
        check({name, " lo"}, lo, exp_lo);
        if (chk_pulse) begin
            @(negedge clk);
            check({name, " done_one_cycle"}, {31'b0, done}, 32'd0);
        end
    endtask

    initial begin
        vecs[0]  = '{"multu_max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult_m3x5",   2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{"mult_10x15",  2'b00, 32'd10,       32'd15,       32'h00000000, 32'h00000096};
        vecs[3]  = '{"mult_min2",   2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[4]  = '{"mult_m1m1",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[5]  = '{"divu_100_7",  2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[6]  = '{"div_m7_2",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[7]  = '{"div_7_m2",    2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[8]  = '{"div_m7_m2",   2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3};
        vecs[9]  = '{"div_min_m1",  2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[10] = '{"divu_by0",    2'b11, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
        vecs[11] = '{"div_m5_by0",  2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[12] = '{"divu_big",    2'b11, 32'hFFFFFFFF, 32'd2,        32'd1,        32'h7FFFFFFF};

        reset   = 1'b1;
        start   = 1'b0;
        md_ctrl = 2'b00;
        srca    = '0;
        srcb    = '0;
        hilo_we = 2'b00;
        wdata   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);

        // Consecutive vectors start in the done cycle of the previous one.
        for (int i = 0; i < 13; i++) begin
            start_op(vecs[i].ctrl, vecs[i].a, vecs[i].b);
            wait_done(vecs[i].name, 0, vecs[i].exp_hi, vecs[i].exp_lo, (i == 0));
        end

        // MTHI/MTLO alongside start: write lands, held during CALC, result overwrites.
        @(negedge clk);
        hilo_we = 2'b11;
        wdata   = 32'h00000055;
        start_op(2'b01, 32'd2, 32'd2);
        hilo_we = 2'b00;
        check("we_with_start hi_held", hi, 32'h00000055);
        check("we_with_start lo_held", lo, 32'h00000055);
        wait_done("we_with_start", 0, 32'd0, 32'd4, 1'b0);

        // start and hilo_we while busy are dropped.
        @(negedge clk);
        start_op(2'b01, 32'd2, 32'd3);
        repeat (10) @(negedge clk);
        start   = 1'b1;
        md_ctrl = 2'b11;
        srca    = 32'd9;
        srcb    = 32'd3;
        hilo_we = 2'b11;
        wdata   = 32'h0000DEAD;
        @(negedge clk);
        start   = 1'b0;
        hilo_we = 2'b00;
        check("busy_we_dropped hi", hi, 32'd0);
        wait_done("busy_ignore", 11, 32'd0, 32'd6, 1'b0);

        @(negedge clk);
        check("no_requeue busy", {31'b0, busy}, 32'd0);
        hilo_we = 2'b10;
        wdata   = 32'h0000BEEF;
        @(negedge clk);
        hilo_we = 2'b00;
        check("mthi hi", hi, 32'h0000BEEF);
        check("mthi lo", lo, 32'd6);
        check("mthi done", {31'b0, done}, 32'd0);
        @(negedge clk);
        check("mthi done_later", {31'b0, done}, 32'd0);

        // Reset during CALC aborts without a HI/LO update or done pulse.
        start_op(2'b01, 32'd7, 32'd7);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort done", {31'b0, done}, 32'd0);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done || busy) seen = 1'b1;
            end
            check("abort quiet", {31'b0, seen}, 32'd0);
        end
        start_op(2'b01, 32'd7, 32'd7);
        wait_done("after_abort", 0, 32'd0, 32'd49, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
